// File: rtl/pulse_freq_meter.sv
// Pulse frequency meter: counts synchronized rising edges of signal_in over a
// window of GATE_CYCLES clocks and reports the count with a one-cycle strobe.
module pulse_freq_meter #(
  parameter int unsigned COUNT_W     = 8,
  parameter int unsigned GATE_CYCLES = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               signal_in,
  output logic [COUNT_W-1:0] count_out,
  output logic               count_valid,
  output logic               overflow,
  output logic               busy
);

  localparam int unsigned        TIMER_W    = $clog2(GATE_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GATE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATE   = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic s1;
  logic s2;
  logic s3;
  logic rise;

  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_next;
  logic [COUNT_W-1:0] edge_cnt;
  logic [COUNT_W-1:0] edge_cnt_next;
  logic [COUNT_W-1:0] edge_acc;
  logic               ovf;
  logic               ovf_next;
  logic               ovf_acc;
  logic [COUNT_W-1:0] count_out_next;
  logic               overflow_next;
  logic               count_valid_next;
  logic               busy_next;

  // Two-flop synchronizer plus one delay stage for edge detection.
  always_ff @(posedge clock) begin : sync_reg
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= signal_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  always_ff @(posedge clock) begin : state_reg
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Dropping enable inside a window aborts it before the timer is considered.
  always_comb begin : next_state_logic
    state_next = state;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_next = GATE;
        end
      end
      GATE: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (timer == TIMER_LAST) begin
          state_next = REPORT;
        end
      end
      REPORT: begin
        state_next = enable ? GATE : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Saturating accumulate; the final gate cycle's edge lands directly in the report.
  always_comb begin : output_logic
    edge_acc = edge_cnt;
    ovf_acc  = ovf;
    if (rise) begin
      if (edge_cnt == COUNT_MAX) begin
        ovf_acc = 1'b1;
      end else begin
        edge_acc = edge_cnt + COUNT_W'(1);
      end
    end

    timer_next       = '0;
    edge_cnt_next    = '0;
    ovf_next         = 1'b0;
    count_out_next   = count_out;
    overflow_next    = overflow;
    count_valid_next = 1'b0;
    busy_next        = (state_next != IDLE);

    if (state == GATE) begin
      if (state_next == GATE) begin
        timer_next    = timer + TIMER_W'(1);
        edge_cnt_next = edge_acc;
        ovf_next      = ovf_acc;
      end else if (state_next == REPORT) begin
        count_out_next   = edge_acc;
        overflow_next    = ovf_acc;
        count_valid_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin : datapath_reg
    if (reset) begin
      timer       <= '0;
      edge_cnt    <= '0;
      ovf         <= 1'b0;
      count_out   <= '0;
      overflow    <= 1'b0;
      count_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      timer       <= timer_next;
      edge_cnt    <= edge_cnt_next;
      ovf         <= ovf_next;
      count_out   <= count_out_next;
      overflow    <= overflow_next;
      count_valid <= count_valid_next;
      busy        <= busy_next;
    end
  end

endmodule

// File: tb/tb_pulse_freq_meter.sv
// Self-checking bench for pulse_freq_meter: a window-level reference model checks
// two instances (8-bit and 3-bit counters) every cycle, plus directed tables/sequences.
module tb_pulse_freq_meter;

  localparam int G    = 16;
  localparam int NMAX = 16384;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       signal_in;
  logic [7:0] count_out8;
  logic [2:0] count_out3;
  logic       valid8, valid3, ovf8, ovf3, busy8, busy3;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  pulse_freq_meter #(.COUNT_W(8), .GATE_CYCLES(G)) dut8 (
    .clock(clock), .reset(reset), .enable(enable), .signal_in(signal_in),
    .count_out(count_out8), .count_valid(valid8), .overflow(ovf8), .busy(busy8)
  );

  pulse_freq_meter #(.COUNT_W(3), .GATE_CYCLES(G)) dut3 (
    .clock(clock), .reset(reset), .enable(enable), .signal_in(signal_in),
    .count_out(count_out3), .count_valid(valid3), .overflow(ovf3), .busy(busy3)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Pattern generator: 0 = constant low, -1 = random, >0 = toggle every N clocks.
  int sig_half = 0;
  int sig_cnt  = 0;
  always @(negedge clock) begin
    if (sig_half < 0) begin
      signal_in = 1'($urandom_range(0, 1));
    end else if (sig_half == 0) begin
      signal_in = 1'b0;
    end else begin
      sig_cnt++;
      if (sig_cnt >= sig_half) begin
        sig_cnt   = 0;
        signal_in = ~signal_in;
      end
    end
  end

  // Reference model: eff[e] is the synchronized sample taken at edge e; a window
  // started at edge ws covers edges ws+1..ws+G, each using the edge seen two samples back.
  typedef enum {M_IDLE, M_GATE, M_REP} mmode_t;
  bit     eff [0:NMAX-1];
  int     e     = 3;
  int     ws    = 0;
  mmode_t mode  = M_IDLE;
  int     x_out8 = 0, x_out3 = 0, x_ovf8 = 0, x_ovf3 = 0, x_valid = 0;
  int     n;

  always @(posedge clock) begin
    cyc++;
    if (e < NMAX) begin
      eff[e] = reset ? 1'b0 : (signal_in === 1'b1);
      if (reset) begin
        eff[e-1] = 1'b0;
        eff[e-2] = 1'b0;
        mode     = M_IDLE;
        x_out8 = 0; x_out3 = 0; x_ovf8 = 0; x_ovf3 = 0; x_valid = 0;
      end else begin
        x_valid = 0;
        case (mode)
          M_IDLE: if (enable) begin mode = M_GATE; ws = e; end
          M_GATE: begin
            if (!enable) begin
              mode = M_IDLE;
            end else if (e == ws + G) begin
              n = 0;
              for (int j = ws + 1; j <= ws + G; j++)
                if (eff[j-2] && !eff[j-3]) n++;
              x_out8 = (n > 255) ? 255 : n;
              x_ovf8 = (n > 255) ? 1 : 0;
              x_out3 = (n > 7) ? 7 : n;
              x_ovf3 = (n > 7) ? 1 : 0;
              x_valid = 1;
              mode = M_REP;
            end
          end
          default: begin
            if (enable) begin mode = M_GATE; ws = e; end
            else mode = M_IDLE;
          end
        endcase
      end
      e++;
      #1;
      chk("m_cnt8",   int'(count_out8), x_out8);
      chk("m_ovf8",   int'(ovf8),       x_ovf8);
      chk("m_valid8", int'(valid8),     x_valid);
      chk("m_busy8",  int'(busy8),      (mode != M_IDLE) ? 1 : 0);
      chk("m_cnt3",   int'(count_out3), x_out3);
      chk("m_ovf3",   int'(ovf3),       x_ovf3);
      chk("m_valid3", int'(valid3),     x_valid);
      chk("m_busy3",  int'(busy3),      (mode != M_IDLE) ? 1 : 0);
    end
  end

  task automatic wait_valid(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clock);
      if (valid8) found = 1'b1;
    end
    chk("valid_seen", int'(found), 1);
  endtask

  typedef struct {
    int half;
    int windows;
    int exp8;
    int eovf8;
    int exp3;
    int eovf3;
  } vec_t;

  vec_t vecs [6];
  bit   found;
  int   last_cyc;
  int   prev;
  int   pulses;
  int   seg_half [6];

  initial begin
    vecs[0] = '{half: 2, windows: 3, exp8: 4, eovf8: 0, exp3: 4, eovf3: 0};
    vecs[1] = '{half: 1, windows: 3, exp8: 8, eovf8: 0, exp3: 7, eovf3: 1};
    vecs[2] = '{half: 2, windows: 2, exp8: 4, eovf8: 0, exp3: 4, eovf3: 0};
    vecs[3] = '{half: 0, windows: 2, exp8: 0, eovf8: 0, exp3: 0, eovf3: 0};
    vecs[4] = '{half: 4, windows: 2, exp8: 2, eovf8: 0, exp3: 2, eovf3: 0};
    vecs[5] = '{half: 8, windows: 2, exp8: 1, eovf8: 0, exp3: 1, eovf3: 0};
    seg_half = '{-1, 1, 2, 3, -1, 5};

    // Reset held for two edges with the input toggling and enable high.
    reset = 1'b1; enable = 1'b1; signal_in = 1'b0; sig_half = 1;
    repeat (2) @(negedge clock);
    chk("rst_cnt",   int'(count_out8), 0);
    chk("rst_ovf",   int'(ovf8),       0);
    chk("rst_valid", int'(valid8),     0);
    chk("rst_busy",  int'(busy8),      0);
    reset = 1'b0; enable = 1'b0; sig_half = 0;
    repeat (4) @(negedge clock);

    for (int r = 0; r < 6; r++) begin
      enable = 1'b0; sig_half = vecs[r].half; sig_cnt = 0;
      repeat (6) @(negedge clock);
      chk("tbl_idle_busy", int'(busy8), 0);
      enable = 1'b1;
      last_cyc = 0;
      for (int w = 0; w < vecs[r].windows; w++) begin
        wait_valid(60, found);
        if (found) begin
          chk("tbl_cnt8", int'(count_out8), vecs[r].exp8);
          chk("tbl_ovf8", int'(ovf8),       vecs[r].eovf8);
          chk("tbl_cnt3", int'(count_out3), vecs[r].exp3);
          chk("tbl_ovf3", int'(ovf3),       vecs[r].eovf3);
          if (w > 0) chk("tbl_period", cyc - last_cyc, G + 1);
          last_cyc = cyc;
        end
      end
      enable = 1'b0;
      repeat (20) @(negedge clock);
    end

    // Abort at gate cycle 5: no report, count_out holds, fresh window starts clean.
    sig_half = 2; sig_cnt = 0;
    repeat (6) @(negedge clock);
    prev = int'(count_out8);
    enable = 1'b1;
    repeat (5) @(negedge clock);
    chk("abort_busy_gate", int'(busy8), 1);
    enable = 1'b0;
    @(negedge clock);
    chk("abort_busy_idle", int'(busy8), 0);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (valid8) pulses++;
    end
    chk("abort_no_valid", pulses, 0);
    chk("abort_hold", int'(count_out8), prev);
    enable = 1'b1;
    wait_valid(40, found);
    if (found) chk("abort_fresh_cnt", int'(count_out8), 4);

    // Enable dropped during REPORT: the strobe stays, then IDLE.
    enable = 1'b0;
    @(negedge clock);
    chk("rep_drop_valid", int'(valid8), 0);
    chk("rep_drop_busy",  int'(busy8),  0);
    repeat (5) @(negedge clock);
    sig_half = 1; sig_cnt = 0;
    repeat (4) @(negedge clock);
    enable = 1'b1;
    wait_valid(40, found);
    enable = 1'b0;
    if (found) chk("rep_drop_cnt3", int'(count_out3), 7);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (valid8) pulses++;
    end
    chk("rep_drop_single", pulses, 0);
    chk("rep_drop_ovf3", int'(ovf3), 1);

    // Reset in the middle of GATE.
    enable = 1'b1;
    repeat (8) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_busy", int'(busy8),      0);
    chk("midrst_cnt",  int'(count_out3), 0);
    chk("midrst_ovf",  int'(ovf3),       0);
    reset = 1'b0; enable = 1'b0;
    repeat (4) @(negedge clock);

    // Randomized run; the reference model checks every cycle.
    for (int s = 0; s < 6; s++) begin
      sig_half = seg_half[s]; sig_cnt = 0;
      for (int i = 0; i < 500; i++) begin
        @(negedge clock);
        if ($urandom_range(0, 99) < 3) enable = ~enable;
        reset = ($urandom_range(0, 999) < 3) ? 1'b1 : 1'b0;
      end
      reset = 1'b0;
      enable = 1'b1;
    end
    reset = 1'b0; enable = 1'b0;
    repeat (5) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
